soc_test_monitor: RTL and testbench
===================================

Name: soc_test_monitor

Overview:
Memory-mapped test-status and signature peripheral on the SoC Wishbone data bus. Firmware reports pass/fail by writing a tohost-style STATUS word and stores up to NUM_CH signature words. The block counts trap events from the core and runs a heartbeat watchdog. Terminal outcome is presented on sticky output pins, so self-checking benches and the FPGA top (LED) read a hardware verdict instead of probing hierarchical register-file paths.

Parameters:
NUM_CH, 4, number of 32-bit signature registers (1..8)
TIMEOUT_W, 24, watchdog counter width
TIMEOUT_INIT, 100000, watchdog reload value after reset
TRAPCNT_W, 16, trap counter width (saturating)
ADR_W, 6, Wishbone byte-address width decoded

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  ADR_W  byte address; bits[1:0] ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
trap_taken_i  in  1  one-cycle pulse per trap taken by the core
done_o  out  1  test finished (PASS or FAIL)
pass_o  out  1  state == PASS
fail_o  out  1  state == FAIL or TIMEOUT
timeout_o  out  1  state == TIMEOUT
irq_o  out  1  level, high while state != RUN

Behaviour:
- Reset: all outputs 0; state RUN; watchdog enabled, count = TIMEOUT_INIT; reload = TIMEOUT_INIT; SIG[*] = 0; trap count = 0; fail code = 0.
- Bus: request = cyc & stb & ~ack. ack is registered one cycle after request and is high for exactly one cycle, so back-to-back accesses take 2 cycles each. Writes commit on the ack cycle and honour sel. wb_dat_o is valid with ack and is 0 otherwise.
- Register map (byte offsets):
  - 0x00 STATUS. Write: bit0 = 1 means done; bits[31:1] = 0 means PASS, nonzero means FAIL with code = bits[31:1]. A write with bit0 = 0 is ignored. Read: {code[30:0], done}.
  - 0x04 CTRL. bit0 = wd_en (RW, reset 1). Bit1 write-1 clears the trap count; reads as 0.
  - 0x08 TIMEOUT. RW reload value, low TIMEOUT_W bits. A write also reloads the counter.
  - 0x0C TRAPCNT. RO, zero-extended.
  - 0x10 + 4i SIG[i], i < NUM_CH. RW. A write to SIG[0] reloads the watchdog (heartbeat).
  - Unmapped offsets: read 0, write ignored, ack still given.
- State machine:
  - RUN -> PASS on a STATUS write with bit0 = 1 and bits[31:1] = 0.
  - RUN -> FAIL on a STATUS write with bit0 = 1 and bits[31:1] != 0; the code is latched.
  - RUN -> TIMEOUT when wd_en = 1 and the count reaches 0.
  - PASS, FAIL and TIMEOUT are terminal until reset. Further STATUS writes are acked and ignored, and the code is not overwritten.
- Watchdog:
  - Decrements by 1 per cycle in RUN when wd_en = 1; holds when wd_en = 0.
  - At count 0 with wd_en = 1, the transition to TIMEOUT occurs on the next edge. No underflow.
  - Frozen in terminal states.
  - Reload value 0 means an immediate TIMEOUT on the next edge if wd_en = 1.
- Trap counter: +1 per trap_taken_i cycle in any state; saturates at all-ones.
- Simultaneous events:
  - STATUS done-write and watchdog expiry in the same cycle: the STATUS write wins.
  - Heartbeat/TIMEOUT write and expiry in the same cycle: the reload wins and the state stays RUN.
  - Trap pulse and CTRL bit1 clear in the same cycle: the result is 0.
- Outputs done_o/pass_o/fail_o/timeout_o/irq_o are registered decodes of the state, with 0 latency from the state register.
- Reset mid-transfer: ack drops immediately and the pending write is discarded.

Test Plan:
- Reset, write 0x00000001 to 0x00 -> ack 1 cycle later; pass_o = done_o = irq_o = 1, fail_o = 0; read 0x00 returns 0x00000001.
- Write 0x0000002B (code 21) to 0x00, then write 0x00000001 -> fail_o = 1, pass_o = 0; read 0x00 = 0x0000002B (second write ignored).
- Write TIMEOUT = 10, no heartbeat -> timeout_o = fail_o = 1 exactly 11 cycles after the write ack. Repeat with SIG[0] writes every 8 cycles for 100 cycles -> state stays RUN.
- Issue 3 trap_taken_i pulses -> TRAPCNT reads 3. Write CTRL = 0x3 -> count 0, wd_en stays 1. With TRAPCNT_W = 2 and 5 pulses -> reads 3.
- SIG[1] = 0xDEADBEEF, then byte write sel = 0b0010 with data 0x00005500 -> reads 0xDEAD55EF. Read unmapped offset 0x3C -> 0, acked.
- Write CTRL = 0, TIMEOUT = 0 -> no timeout for 1000 cycles. Write CTRL = 1 -> timeout_o = 1 on the next edge. Assert reset_n low mid-ack -> all outputs 0 immediately.

Source files
------------

// File: rtl/soc_test_monitor.sv
// Test-status / signature peripheral on the Wishbone data bus.
// Ports: clk, reset_n, wb_* slave, trap_taken_i, verdict pins (done/pass/fail/timeout/irq).
module soc_test_monitor #(
  parameter int NUM_CH       = 4,
  parameter int TIMEOUT_W    = 24,
  parameter int TIMEOUT_INIT = 100000,
  parameter int TRAPCNT_W    = 16,
  parameter int ADR_W        = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic             trap_taken_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic             irq_o
);

  localparam int OW  = ADR_W - 2;
  localparam int SIW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TMO
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic [30:0]           r_code;
  logic                  r_wd_en;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic [TIMEOUT_W-1:0]  r_reload;
  logic [TRAPCNT_W-1:0]  r_trap;
  logic [31:0]           r_sig [NUM_CH];
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;
  logic                  r_tmo;
  logic                  r_irq;

  logic [OW-1:0]  w_off;
  logic [OW-1:0]  w_sidx_full;
  logic [SIW-1:0] w_sidx;
  logic           w_is_stat;
  logic           w_is_ctrl;
  logic           w_is_tmo;
  logic           w_is_trap;
  logic           w_is_sig;
  logic [31:0]    w_rd;
  logic [31:0]    w_mask;
  logic [31:0]    w_wdat;
  logic           w_req;
  logic           w_wr;
  logic           w_done_wr;
  logic           w_hb;
  logic           w_unused;

  assign w_off       = wb_adr_i[ADR_W-1:2];
  assign w_sidx_full = w_off - OW'(4);
  assign w_sidx      = w_sidx_full[SIW-1:0];
  assign w_is_stat   = (w_off == OW'(0));
  assign w_is_ctrl   = (w_off == OW'(1));
  assign w_is_tmo    = (w_off == OW'(2));
  assign w_is_trap   = (w_off == OW'(3));
  assign w_is_sig    = (w_off >= OW'(4)) &&
                       (int'(w_sidx_full) < NUM_CH);
  assign w_unused    = ^wb_adr_i[1:0];

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_is_stat: w_rd = {r_code, r_done};
      w_is_ctrl: w_rd = {31'd0, r_wd_en};
      w_is_tmo:  w_rd = 32'(r_reload);
      w_is_trap: w_rd = 32'(r_trap);
      w_is_sig:  w_rd = r_sig[w_sidx];
      default:   w_rd = '0;
    endcase
  end

  // Byte lanes not selected keep the register's current value.
  assign w_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                   {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wdat = (w_rd & ~w_mask) | (wb_dat_i & w_mask);

  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = r_ack & wb_cyc_i & wb_stb_i & wb_we_i;
  assign w_done_wr = w_wr & w_is_stat & w_wdat[0];
  assign w_hb      = w_wr & w_is_sig & (w_sidx_full == '0);

  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_ack ? w_rd : '0;
  assign done_o    = r_done;
  assign pass_o    = r_pass;
  assign fail_o    = r_fail;
  assign timeout_o = r_tmo;
  assign irq_o     = r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_RUN;
      r_ack    <= 1'b0;
      r_code   <= '0;
      r_wd_en  <= 1'b1;
      r_cnt    <= TIMEOUT_W'(TIMEOUT_INIT);
      r_reload <= TIMEOUT_W'(TIMEOUT_INIT);
      r_trap   <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_tmo    <= 1'b0;
      r_irq    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_sig[i] <= '0;
    end else begin
      r_ack <= w_req;

      // Clear beats a coincident trap pulse.
      if (w_wr && w_is_ctrl && w_wdat[1])
        r_trap <= '0;
      else if (trap_taken_i && (r_trap != '1))
        r_trap <= r_trap + 1'b1;

      if (w_wr && w_is_ctrl) r_wd_en <= w_wdat[0];
      if (w_wr && w_is_tmo) r_reload <= w_wdat[TIMEOUT_W-1:0];
      if (w_wr && w_is_sig) r_sig[w_sidx] <= w_wdat;

      unique case (r_state)
        S_RUN: begin
          if (w_done_wr) begin
            r_done <= 1'b1;
            r_irq  <= 1'b1;
            if (w_wdat[31:1] == '0) begin
              r_state <= S_PASS;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
              r_code  <= w_wdat[31:1];
            end
          end else if (w_wr && w_is_tmo) begin
            r_cnt <= w_wdat[TIMEOUT_W-1:0];
          end else if (w_hb) begin
            r_cnt <= r_reload;
          end else if (r_wd_en) begin
            if (r_cnt == '0) begin
              r_state <= S_TMO;
              r_done  <= 1'b1;
              r_fail  <= 1'b1;
              r_tmo   <= 1'b1;
              r_irq   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_test_monitor.sv
// Directed self-checking bench for soc_test_monitor.
// Second instance uses a 2-bit trap counter for saturation.
module tb_soc_test_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [5:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        trap = 1'b0;

  logic [31:0] dat_o, dat_o2;
  logic        ack, ack2;
  logic        done, pass, fail, tmo, irq;
  logic        done2, pass2, fail2, tmo2, irq2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd2;

  always #5 clk = ~clk;

  soc_test_monitor dut (
    .clk(clk), .reset_n(reset_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_dat_o(dat_o), .wb_ack_o(ack),
    .trap_taken_i(trap),
    .done_o(done), .pass_o(pass), .fail_o(fail),
    .timeout_o(tmo), .irq_o(irq)
  );

  soc_test_monitor #(.TRAPCNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_dat_o(dat_o2), .wb_ack_o(ack2),
    .trap_taken_i(trap),
    .done_o(done2), .pass_o(pass2), .fail_o(fail2),
    .timeout_o(tmo2), .irq_o(irq2)
  );

  task automatic bus(input logic w, input logic [5:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int lat);
    lat = -1;
    rd  = '0;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; dat = d; sel = s;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        rd  = dat_o;
        rd2 = dat_o2;
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat < 0) begin
      n_bad++;
      $display("FAIL ack_timeout adr=%h: no ack within 8 cycles", a);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; trap = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int l;
    do_reset();
    n_cmp++;
    if ({done, pass, fail, tmo, irq, ack} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outs got %b want 000000",
               {done, pass, fail, tmo, irq, ack});
    end
    bus(1'b0, 6'h04, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'h1) begin
      n_bad++;
      $display("FAIL reset_ctrl got %h want 00000001", r);
    end
    bus(1'b0, 6'h08, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'd100000) begin
      n_bad++;
      $display("FAIL reset_timeout got %h want %h", r, 32'd100000);
    end
    bus(1'b0, 6'h10, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_sig0 got %h want 0", r);
    end
  endtask

  task automatic test_pass();
    logic [31:0] r;
    int l;
    do_reset();
    bus(1'b1, 6'h00, 32'h1, 4'hF, r, l);
    n_cmp++;
    if (l !== 1) begin
      n_bad++;
      $display("FAIL pass_ack_lat got %0d want 1", l);
    end
    n_cmp++;
    if ({pass, done, irq, fail, tmo} !== 5'b11100) begin
      n_bad++;
      $display("FAIL pass_outs got %b want 11100",
               {pass, done, irq, fail, tmo});
    end
    bus(1'b0, 6'h00, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'h1) begin
      n_bad++;
      $display("FAIL pass_status got %h want 00000001", r);
    end
  endtask

  task automatic test_fail_code();
    logic [31:0] r;
    int l;
    do_reset();
    bus(1'b1, 6'h00, 32'h2B, 4'hF, r, l);
    bus(1'b1, 6'h00, 32'h1, 4'hF, r, l);
    n_cmp++;
    if ({fail, pass, done, tmo} !== 4'b1010) begin
      n_bad++;
      $display("FAIL fail_outs got %b want 1010",
               {fail, pass, done, tmo});
    end
    bus(1'b0, 6'h00, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'h2B) begin
      n_bad++;
      $display("FAIL fail_status got %h want 0000002b", r);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] r;
    int l;
    do_reset();
    bus(1'b1, 6'h08, 32'd10, 4'hF, r, l);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        n_cmp++;
        if (tmo !== 1'b0) begin
          n_bad++;
          $display("FAIL wd_early got %b want 0 at cycle 10", tmo);
        end
      end
      if (k == 11) begin
        n_cmp++;
        if ({tmo, fail, done, pass} !== 4'b1110) begin
          n_bad++;
          $display("FAIL wd_expire got %b want 1110",
                   {tmo, fail, done, pass});
        end
      end
    end
  endtask

  task automatic test_heartbeat();
    logic [31:0] r;
    int l;
    do_reset();
    bus(1'b1, 6'h08, 32'd10, 4'hF, r, l);
    for (int k = 0; k < 13; k++) begin
      repeat (5) @(posedge clk);
      #1;
      bus(1'b1, 6'h10, k, 4'hF, r, l);
    end
    n_cmp++;
    if ({tmo, irq, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL heartbeat got %b want 000", {tmo, irq, done});
    end
    bus(1'b0, 6'h10, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'd12) begin
      n_bad++;
      $display("FAIL hb_sig0 got %h want 0000000c", r);
    end
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      trap = 1'b1;
      @(posedge clk); #1;
      trap = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_traps();
    logic [31:0] r;
    int l;
    do_reset();
    pulses(3);
    bus(1'b0, 6'h0C, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'd3) begin
      n_bad++;
      $display("FAIL trap_cnt3 got %h want 00000003", r);
    end
    bus(1'b1, 6'h04, 32'h3, 4'hF, r, l);
    bus(1'b0, 6'h0C, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'd0) begin
      n_bad++;
      $display("FAIL trap_clr got %h want 0", r);
    end
    bus(1'b0, 6'h04, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'h1) begin
      n_bad++;
      $display("FAIL trap_wden got %h want 00000001", r);
    end
    pulses(5);
    bus(1'b0, 6'h0C, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'd5) begin
      n_bad++;
      $display("FAIL trap_cnt5 got %h want 00000005", r);
    end
    n_cmp++;
    if (rd2 !== 32'd3) begin
      n_bad++;
      $display("FAIL trap_sat got %h want 00000003", rd2);
    end
  endtask

  task automatic test_sig_bytes();
    logic [31:0] r;
    int l;
    do_reset();
    bus(1'b1, 6'h14, 32'hDEADBEEF, 4'hF, r, l);
    bus(1'b1, 6'h14, 32'h00005500, 4'b0010, r, l);
    bus(1'b0, 6'h14, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'hDEAD55EF) begin
      n_bad++;
      $display("FAIL sig_bytes got %h want dead55ef", r);
    end
    bus(1'b1, 6'h3C, 32'hFFFFFFFF, 4'hF, r, l);
    bus(1'b0, 6'h3C, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'h0 || l !== 1) begin
      n_bad++;
      $display("FAIL unmapped got %h lat %0d want 0 lat 1", r, l);
    end
  endtask

  task automatic test_wd_disable();
    logic [31:0] r;
    int l;
    do_reset();
    bus(1'b1, 6'h04, 32'h0, 4'hF, r, l);
    bus(1'b1, 6'h08, 32'h0, 4'hF, r, l);
    repeat (1000) @(posedge clk);
    #1;
    n_cmp++;
    if (tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_off got %b want 0", tmo);
    end
    bus(1'b1, 6'h04, 32'h1, 4'hF, r, l);
    n_cmp++;
    if (tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_on_early got %b want 0", tmo);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tmo !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_on_expire got %b want 1", tmo);
    end
  endtask

  task automatic test_reset_mid_ack();
    logic [31:0] r;
    int l;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 6'h00; dat = 32'h1; sel = 4'hF;
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_ack_pre got %b want 1", ack);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack, done, pass, fail, tmo, irq} !== 6'b0 ||
        dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_ack_rst got %b dat %h want 000000 dat 0",
               {ack, done, pass, fail, tmo, irq}, dat_o);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus(1'b0, 6'h00, 32'h0, 4'hF, r, l);
    n_cmp++;
    if (r !== 32'h0 || pass !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_ack_discard got %h pass %b want 0 0", r, pass);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_code();
    test_watchdog();
    test_heartbeat();
    test_traps();
    test_sig_bytes();
    test_wd_disable();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
